// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-issue scheduler between instruction buffer and ID decoders
module issue_scheduler #(
    parameter int DIV_LAT = 33,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              stall_id,
    input  logic              i1_valid,
    input  logic              i2_valid,
    input  logic [REG_AW-1:0] i1_rs,
    input  logic [REG_AW-1:0] i1_rt,
    input  logic [REG_AW-1:0] i2_rs,
    input  logic [REG_AW-1:0] i2_rt,
    input  logic [1:0]        i1_rd_use,
    input  logic [1:0]        i2_rd_use,
    input  logic              i1_we,
    input  logic              i2_we,
    input  logic [REG_AW-1:0] i1_waddr,
    input  logic [REG_AW-1:0] i2_waddr,
    input  logic [4:0]        i1_cls,
    input  logic [4:0]        i2_cls,
    output logic              issue1,
    output logic              issue2,
    output logic [1:0]        pop_num,
    output logic              stallreq,
    output logic              div_busy,
    output logic              in_ds
);

    localparam int CLS_BR   = 0;
    localparam int CLS_MEM  = 1;
    localparam int CLS_DIV  = 2;
    localparam int CLS_HILO = 3;
    localparam int CLS_PRIV = 4;

    localparam int               CNT_W    = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {DS_NORMAL, DS_PEND}  ds_state_t;
    typedef enum logic {DIV_IDLE,  DIV_BUSY} div_state_t;

    ds_state_t                     ds_state, ds_state_n;
    div_state_t                    div_state, div_state_n;
    logic [CNT_W-1:0]              div_cnt, div_cnt_n;
    logic [1:0]                    ld_v, ld_v_n;
    logic [1:0][REG_AW-1:0]        ld_addr, ld_addr_n;

    logic blk1, pair_hazard, ld_hit1, ld_hit2, raw, waw, can_issue;

    // A read of r0 or an unused operand never matches.
    function automatic logic src_hit(input logic rd, input logic [REG_AW-1:0] src,
                                     input logic v, input logic [REG_AW-1:0] dst);
        return rd && (src != '0) && v && (src == dst);
    endfunction

    always_comb begin
        ld_hit1 = src_hit(i1_rd_use[1], i1_rs, ld_v[0], ld_addr[0])
                | src_hit(i1_rd_use[1], i1_rs, ld_v[1], ld_addr[1])
                | src_hit(i1_rd_use[0], i1_rt, ld_v[0], ld_addr[0])
                | src_hit(i1_rd_use[0], i1_rt, ld_v[1], ld_addr[1]);
        ld_hit2 = src_hit(i2_rd_use[1], i2_rs, ld_v[0], ld_addr[0])
                | src_hit(i2_rd_use[1], i2_rs, ld_v[1], ld_addr[1])
                | src_hit(i2_rd_use[0], i2_rt, ld_v[0], ld_addr[0])
                | src_hit(i2_rd_use[0], i2_rt, ld_v[1], ld_addr[1]);
        raw = src_hit(i2_rd_use[1], i2_rs, i1_we, i1_waddr)
            | src_hit(i2_rd_use[0], i2_rt, i1_we, i1_waddr);
        waw = i1_we & i2_we & (i1_waddr != '0) & (i1_waddr == i2_waddr);

        blk1 = ld_hit1 | (div_busy & (i1_cls[CLS_HILO] | i1_cls[CLS_DIV]));
        pair_hazard = raw | waw
                    | (i1_cls[CLS_MEM] & i2_cls[CLS_MEM])
                    | i2_cls[CLS_PRIV] | i2_cls[CLS_DIV] | i2_cls[CLS_BR]
                    | i1_cls[CLS_PRIV]
                    | ld_hit2
                    | ((i2_cls[CLS_HILO] | i2_cls[CLS_DIV]) & (div_busy | i1_cls[CLS_DIV]));
    end

    always_comb begin
        div_busy  = (div_state == DIV_BUSY);
        in_ds     = (ds_state == DS_PEND);
        can_issue = resetn & ~stall_id & ~flush;
        issue1    = can_issue & i1_valid & ~blk1;
        issue2    = issue1 & i2_valid & ~pair_hazard & (ds_state == DS_NORMAL);
        pop_num   = {1'b0, issue1} + {1'b0, issue2};
        stallreq  = resetn & i1_valid & ~issue1 & ~stall_id & ~flush;
    end

    always_comb begin
        ds_state_n  = ds_state;
        div_state_n = div_state;
        div_cnt_n   = div_cnt;
        ld_v_n      = ld_v;
        ld_addr_n   = ld_addr;

        if (flush) begin
            ds_state_n  = DS_NORMAL;
            div_state_n = DIV_IDLE;
            div_cnt_n   = '0;
            ld_v_n      = '0;
        end else begin
            case (ds_state)
                DS_NORMAL: if (issue1 && i1_cls[CLS_BR] && (pair_hazard || !i2_valid))
                               ds_state_n = DS_PEND;
                DS_PEND:   if (issue1) ds_state_n = DS_NORMAL;
                default:   ds_state_n = DS_NORMAL;
            endcase

            // The counter runs through downstream stalls; only flush/reset stop it.
            case (div_state)
                DIV_IDLE: if (issue1 && i1_cls[CLS_DIV]) begin
                    div_state_n = DIV_BUSY;
                    div_cnt_n   = CNT_LOAD;
                end
                DIV_BUSY: if (div_cnt == CNT_ONE) begin
                    div_state_n = DIV_IDLE;
                    div_cnt_n   = '0;
                end else begin
                    div_cnt_n = div_cnt - CNT_ONE;
                end
                default: begin
                    div_state_n = DIV_IDLE;
                    div_cnt_n   = '0;
                end
            endcase

            if (issue1) begin
                ld_v_n[0]    = i1_we & i1_cls[CLS_MEM] & (i1_waddr != '0);
                ld_v_n[1]    = issue2 & i2_we & i2_cls[CLS_MEM] & (i2_waddr != '0);
                ld_addr_n[0] = i1_waddr;
                ld_addr_n[1] = i2_waddr;
            end else if (!stall_id) begin
                ld_v_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_state  <= DS_NORMAL;
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            ld_v      <= '0;
            ld_addr   <= '0;
        end else begin
            ds_state  <= ds_state_n;
            div_state <= div_state_n;
            div_cnt   <= div_cnt_n;
            ld_v      <= ld_v_n;
            ld_addr   <= ld_addr_n;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler
module tb_issue_scheduler;

    logic       clk = 1'b0;
    logic       resetn, flush, stall_id;
    logic       i1_valid, i2_valid;
    logic [4:0] i1_rs, i1_rt, i2_rs, i2_rt, i1_waddr, i2_waddr;
    logic [1:0] i1_rd_use, i2_rd_use;
    logic       i1_we, i2_we;
    logic [4:0] i1_cls, i2_cls;
    logic       issue1, issue2, stallreq, div_busy, in_ds;
    logic [1:0] pop_num;

    // {issue1, issue2, pop_num[1:0], stallreq, div_busy, in_ds}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_DUAL  = 7'b1110000;
    localparam logic [6:0] E_ONE   = 7'b1001000;
    localparam logic [6:0] E_ONEDS = 7'b1001001;
    localparam logic [6:0] E_STALL = 7'b0000100;
    localparam logic [6:0] E_BSTL  = 7'b0000110;
    localparam logic [6:0] E_BHOLD = 7'b0000010;

    localparam logic [4:0] C_ALU = 5'b00000, C_BR = 5'b00001, C_MEM = 5'b00010,
                           C_DIV = 5'b00100, C_HILO = 5'b01000, C_PRIV = 5'b10000;

    int checks = 0;
    int failures = 0;
    logic [6:0] exp_q[$];
    string      tag_q[$];

    issue_scheduler #(.DIV_LAT(33), .REG_AW(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall_id(stall_id),
        .i1_valid(i1_valid), .i2_valid(i2_valid),
        .i1_rs(i1_rs), .i1_rt(i1_rt), .i2_rs(i2_rs), .i2_rt(i2_rt),
        .i1_rd_use(i1_rd_use), .i2_rd_use(i2_rd_use),
        .i1_we(i1_we), .i2_we(i2_we), .i1_waddr(i1_waddr), .i2_waddr(i2_waddr),
        .i1_cls(i1_cls), .i2_cls(i2_cls),
        .issue1(issue1), .issue2(issue2), .pop_num(pop_num),
        .stallreq(stallreq), .div_busy(div_busy), .in_ds(in_ds)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic set_i1(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] use_, input logic we, input logic [4:0] wa,
                          input logic [4:0] cls);
        i1_valid = v; i1_rs = rs; i1_rt = rt; i1_rd_use = use_;
        i1_we = we; i1_waddr = wa; i1_cls = cls;
    endtask

    task automatic set_i2(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] use_, input logic we, input logic [4:0] wa,
                          input logic [4:0] cls);
        i2_valid = v; i2_rs = rs; i2_rt = rt; i2_rd_use = use_;
        i2_we = we; i2_waddr = wa; i2_cls = cls;
    endtask

    task automatic clear_in();
        flush = 0; stall_id = 0;
        set_i1(0, 0, 0, 2'b00, 0, 0, C_ALU);
        set_i2(0, 0, 0, 2'b00, 0, 0, C_ALU);
    endtask

    // Push the expectation with the stimulus, compare at the negedge, commit at posedge.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        got = {issue1, issue2, pop_num, stallreq, div_busy, in_ds};
        check_eq(tag_q.pop_front(), got, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 0;
        clear_in();
        set_i1(1, 2, 3, 2'b11, 1, 1, C_ALU);
        step("reset", E_IDLE);
        resetn = 1;

        // independent ALU pair
        set_i1(1, 2, 3, 2'b11, 1, 1, C_ALU);
        set_i2(1, 5, 6, 2'b11, 1, 4, C_ALU);
        step("alu_pair", E_DUAL);
        // intra-pair RAW, WAW, both mem, r0 no dependence, i1 priv
        set_i2(1, 1, 6, 2'b11, 1, 4, C_ALU);       step("raw", E_ONE);
        set_i2(1, 5, 6, 2'b11, 1, 1, C_ALU);       step("waw", E_ONE);
        set_i1(1, 2, 0, 2'b10, 1, 7, C_MEM);
        set_i2(1, 3, 0, 2'b10, 0, 0, C_MEM);       step("mem_mem", E_ONE);
        clear_in();
        set_i1(1, 2, 3, 2'b11, 1, 0, C_ALU);
        set_i2(1, 0, 0, 2'b11, 1, 4, C_ALU);       step("r0", E_DUAL);
        set_i1(1, 0, 0, 2'b00, 0, 0, C_PRIV);
        set_i2(1, 5, 6, 2'b11, 1, 4, C_ALU);       step("i1_priv", E_ONE);

        // load-use in slot 1
        clear_in();
        set_i1(1, 2, 0, 2'b10, 1, 8, C_MEM);
        set_i2(1, 11, 12, 2'b11, 1, 10, C_ALU);    step("lw_n", E_DUAL);
        clear_in();
        set_i1(1, 8, 0, 2'b11, 1, 9, C_ALU);       step("lu_n1", E_STALL);
        step("lu_n2", E_ONE);
        // load in slot 2, then i2 depends on it
        set_i1(1, 11, 12, 2'b11, 1, 10, C_ALU);
        set_i2(1, 2, 0, 2'b10, 1, 8, C_MEM);       step("lw_s2", E_DUAL);
        set_i1(1, 2, 3, 2'b11, 1, 1, C_ALU);
        set_i2(1, 8, 5, 2'b11, 1, 4, C_ALU);       step("lu_s2", E_ONE);

        // beq alone, then delay slot alone
        clear_in();
        set_i1(1, 1, 2, 2'b11, 0, 0, C_BR);        step("beq", E_ONE);
        set_i1(1, 2, 3, 2'b11, 1, 1, C_ALU);
        set_i2(1, 5, 6, 2'b11, 1, 4, C_ALU);       step("beq_ds", E_ONEDS);
        clear_in();                                step("beq_after", E_IDLE);
        // jal + reader of $31
        set_i1(1, 0, 0, 2'b00, 1, 31, C_BR);
        set_i2(1, 31, 0, 2'b10, 1, 4, C_ALU);      step("jal", E_ONE);
        set_i1(1, 31, 0, 2'b10, 1, 4, C_ALU);
        set_i2(1, 5, 6, 2'b11, 1, 9, C_ALU);       step("jal_ds", E_ONEDS);
        // branch paired with its delay slot
        set_i1(1, 1, 2, 2'b11, 0, 0, C_BR);
        set_i2(1, 5, 6, 2'b11, 1, 9, C_ALU);       step("br_pair", E_DUAL);
        clear_in();                                step("br_pair_after", E_IDLE);

        // div then mfhi: 32 busy cycles, issue on 33rd
        set_i1(1, 4, 5, 2'b11, 0, 0, C_DIV);
        set_i2(1, 0, 0, 2'b00, 1, 7, C_HILO);      step("div", E_ONE);
        clear_in();
        set_i1(1, 0, 0, 2'b00, 1, 7, C_HILO);
        for (int k = 1; k <= 32; k++) step($sformatf("div_busy_%0d", k), E_BSTL);
        step("mfhi_issue", E_ONE);

        // counter keeps running under stall_id
        set_i1(1, 4, 5, 2'b11, 0, 0, C_DIV);       step("div_s", E_ONE);
        set_i1(1, 0, 0, 2'b00, 1, 7, C_HILO);
        stall_id = 1;
        for (int k = 1; k <= 32; k++) step($sformatf("div_stall_%0d", k), E_BHOLD);
        stall_id = 0;                              step("mfhi_after_stall", E_ONE);

        // flush at cycle 10 of busy
        set_i1(1, 4, 5, 2'b11, 0, 0, C_DIV);       step("div_f", E_ONE);
        set_i1(1, 0, 0, 2'b00, 1, 7, C_HILO);
        for (int k = 1; k <= 9; k++) step($sformatf("div_f_busy_%0d", k), E_BSTL);
        flush = 1;                                 step("flush_busy", E_BHOLD);
        flush = 0;                                 step("flush_mfhi", E_ONE);
        // flush wins over a div issue
        set_i1(1, 4, 5, 2'b11, 0, 0, C_DIV);
        flush = 1;                                 step("flush_div", E_IDLE);
        clear_in();                                step("flush_div_after", E_IDLE);

        // stall_id with a pending load and dependent slot 1
        set_i1(1, 2, 0, 2'b10, 1, 8, C_MEM);       step("lw_st", E_ONE);
        set_i1(1, 8, 0, 2'b11, 1, 9, C_ALU);
        stall_id = 1;
        for (int k = 1; k <= 3; k++) step($sformatf("stall_%0d", k), E_IDLE);
        stall_id = 0;                              step("stall_bubble", E_STALL);
        step("stall_issue", E_ONE);
        // flush clears the load tracker
        set_i1(1, 2, 0, 2'b10, 1, 8, C_MEM);       step("lw_fl", E_ONE);
        set_i1(1, 8, 0, 2'b11, 1, 9, C_ALU);
        flush = 1;                                 step("flush_ld", E_IDLE);
        flush = 0;                                 step("flush_ld_issue", E_ONE);

        // async reset mid-BUSY
        set_i1(1, 4, 5, 2'b11, 0, 0, C_DIV);       step("div_r", E_ONE);
        set_i1(1, 0, 0, 2'b00, 1, 7, C_HILO);      step("div_r_busy", E_BSTL);
        #1 resetn = 0;                             step("rst_async", E_IDLE);
        resetn = 1;                                step("rst_mfhi", E_ONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Dual-issue scheduler between the instruction buffer and the two ID decoders. Each cycle it inspects the two head entries of the buffer and decides how many to issue: 0, 1 (slot 1 only) or 2. The decision accounts for intra-pair dependences, load-use hazards, branch/delay-slot pairing and divider occupancy. It drives the buffer pop count and the ID stall request.

Parameters:
DIV_LAT, 33, divider occupancy in cycles counted from the issue cycle (must be >= 2)
REG_AW, 5, register address width

Ports:
clk  in  1  pipeline clock; the only clock
resetn  in  1  reset, asynchronous and active-low
flush  in  1  pipeline flush (exception/eret); clears all state
stall_id  in  1  downstream stall; no issue this cycle
i1_valid, i2_valid  in  1  buffer head / head+1 entry valid
i1_rs, i1_rt, i2_rs, i2_rt  in  REG_AW  source register addresses
i1_rd_use, i2_rd_use  in  2  {reads_rs, reads_rt}
i1_we, i2_we  in  1  writes GPR
i1_waddr, i2_waddr  in  REG_AW  GPR destination
i1_cls, i2_cls  in  5  {priv, hilo, div, mem, br}; priv = cp0/eret/syscall/break
issue1, issue2  out  1  slot issued this cycle (issue2 implies issue1)
pop_num  out  2  entries to pop = issue1+issue2
stallreq  out  1  slot 1 valid but held by a hazard
div_busy  out  1  divider FSM in BUSY
in_ds  out  1  DS FSM in DS_PEND

Behaviour:
- Outputs are combinational from inputs and registered state (0-cycle latency). State updates on the posedge.
- While resetn=0 all state clears and all outputs read 0.
- Register r0 never creates a dependence.
- Load tracker: ld_v[1:0] and ld_addr[1:0] record GPR-writing mem instructions issued in the previous issuing cycle.
  - On an issuing cycle, it loads the flags of the issued slots.
  - On a non-issuing cycle with stall_id=0 (bubble), it clears.
  - On stall_id=1, it holds.
- blk1: slot-1 read source matches a valid ld_addr; OR div_busy & (i1 hilo|div).
- Pair hazard (forces single issue): any of the following.
  - i2 reads a register i1 writes.
  - i1_we & i2_we & same waddr.
  - Both slots mem.
  - i2 priv, div or br.
  - i1 priv.
  - i2 read matches a valid ld_addr.
  - i2 hilo|div while div_busy or i1 div.
- Issue rule in state NORMAL, with stall_id=0, flush=0:
  - issue1 = i1_valid & ~blk1.
  - issue2 = issue1 & i2_valid & ~pair_hazard.
- Branch FSM (NORMAL, DS_PEND):
  - Slot-1 branch with pair hazard or ~i2_valid: branch issues alone, go DS_PEND.
  - Slot-1 branch otherwise: dual issue with its delay slot, stay NORMAL.
  - In DS_PEND: issue2 forced 0; when slot 1 (the delay slot) issues, return to NORMAL.
  - flush → NORMAL.
- Divider FSM (IDLE, BUSY):
  - Issuing a div (slot 1 only) loads cnt=DIV_LAT-1 and enters BUSY.
  - In BUSY, cnt decrements every cycle, including during stall_id. cnt=1 → IDLE next cycle.
  - flush or reset → IDLE, cnt=0.
  - div_busy=1 during BUSY.
- stallreq = i1_valid & ~issue1 & ~stall_id & ~flush.
- stall_id=1: issue1=issue2=pop_num=0 and stallreq=0. FSMs hold, except the divider counter.
- flush=1: no issue, and all of the following clear the same cycle: ld_v, DS FSM, divider FSM.
- Simultaneous cases:
  - flush with a div issue attempt: flush wins.
  - Divider reaching IDLE while slot 1 is a waiting mfhi: mfhi issues the cycle after cnt=1.
- Reset asserted mid-operation: immediate (async) return to reset state.

Test Plan:
- Independent ALU pair, i1 add $1,$2,$3, i2 sub $4,$5,$6 → issue1=1, issue2=1, pop_num=2, stallreq=0.
- i1 lw $8, then next pair i1 addu $9,$8,$0 → cycle N: load issues (with i2 per rules); cycle N+1: issue1=0, stallreq=1, pop_num=0; cycle N+2: issue1=1.
- i1 beq, i2_valid=0 → issue1=1, pop_num=1, in_ds=1 next cycle; next cycle delay slot plus valid i2 → issue1=1, issue2=0, in_ds returns 0.
- i1 jal (writes $31), i2 reads $31 → branch alone, DS_PEND, then delay slot alone.
- div issued with DIV_LAT=33, followed by mfhi → div_busy=1 for 32 cycles, stallreq=1 throughout, mfhi issues on the 33rd cycle after div issue. Repeat with flush at cycle 10 → div_busy=0 next cycle.
- stall_id=1 for 3 cycles with a load pending and a dependent slot 1 → outputs 0 and ld_v held. After release → 1-cycle bubble, then issue. resetn low mid-BUSY → div_busy=0 immediately.
